// File: rtl/aes_pkg.sv
// Shared AES byte-serial definitions: state size, MixColumns enable codes, ShiftRows index map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

    localparam int AES_STATE_BYTES = 16;

    // MixColumns accumulator feedback mask: zero restarts a column, all-ones accumulates.
    localparam logic [7:0] MC_EN_FIRST = 8'h00;
    localparam logic [7:0] MC_EN_ACC   = 8'hFF;

    // Output position k (column-major, k = r + 4*c) takes its byte from input
    // row r, column (c + r) mod 4. The 2-bit add wraps for the mod 4.
    function automatic logic [3:0] shift_rows_src(input logic [3:0] k);
        logic [1:0] r;
        logic [1:0] c;
        r = k[1:0];
        c = k[3:2] + k[1:0];
        return {c, r};
    endfunction

endpackage

// File: rtl/shift_rows_serial_if.sv
// Byte-serial ShiftRows bus: input byte stream plus the framed output stream to MixColumns.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready on the input side; the output side has none.
interface shift_rows_serial_if;
    logic [7:0] in_byte;     // state byte, column-major s0..s15
    logic       in_valid;    // in_byte valid this cycle
    logic       in_ready;    // block accepts a byte this cycle
    logic [7:0] out_byte;    // ShiftRows-ordered byte to MixColumns
    logic       out_valid;   // out_byte valid
    logic [7:0] mc_enable;   // 00 on first byte of a column, FF otherwise
    logic       col_last;    // 4th byte of an output column
    logic       state_last;  // 16th byte of an output state

    // Block side.
    modport slave (
        input  in_byte, in_valid,
        output in_ready, out_byte, out_valid, mc_enable, col_last, state_last
    );

    // Upstream source / downstream sink side.
    modport master (
        output in_byte, in_valid,
        input  in_ready, out_byte, out_valid, mc_enable, col_last, state_last
    );
endinterface

// File: rtl/state_bank_2x16.sv
// Ping-pong pair of 16-byte AES state banks, one write port and one combinational read port.
// Latency: write lands at the clock edge; read data follows rd_bank/rd_idx combinationally.
// Backpressure: none; the controller never writes a bank it is reading.
//
// Ports:
//   clock            rising-edge clock
//   wr_en/wr_bank/wr_idx/wr_dat   write strobe, bank select, byte index, data
//   rd_bank/rd_idx   read bank select and byte index
//   rd_dat           byte at bank[rd_bank][rd_idx]
module state_bank_2x16
    import aes_pkg::*;
(
    input  logic       clock,
    input  logic       wr_en,
    input  logic       wr_bank,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_dat,
    input  logic       rd_bank,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_dat
);

    // Contents are not reset: a bank is only read after it has been fully written.
    logic [7:0] mem [2][AES_STATE_BYTES];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_bank][rd_idx];

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows with ping-pong buffering, framed for a byte-serial MixColumns.
// Latency: first output byte registered one edge after the edge accepting the 16th input byte.
// Backpressure: in_ready drops only when both banks hold unsent states; output never stalls.
//
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset; discards any buffered or in-flight state
//   bus     shift_rows_serial_if.slave: in_byte/in_valid/in_ready input stream,
//           out_byte/out_valid/mc_enable/col_last/state_last output stream
module shift_rows_serial
    import aes_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    shift_rows_serial_if.slave    bus
);

    logic [1:0] full;      // per-bank "complete state waiting or streaming" flag
    logic       wr_bank;
    logic       rd_bank;
    logic [3:0] wr_idx;
    logic [3:0] rd_idx;
    logic       wr_fire;
    logic       rd_active;
    logic [3:0] rd_src;
    logic [7:0] rd_dat;

    logic [7:0] out_byte_q;
    logic       out_valid_q;
    logic [7:0] mc_enable_q;
    logic       col_last_q;
    logic       state_last_q;

    assign bus.in_ready = !full[wr_bank] && !reset;
    assign wr_fire      = bus.in_valid && bus.in_ready;

    // The read side streams exactly while the bank under the read pointer is full:
    // the flag stays set through k = 0..15 and is cleared on k = 15, so the idle /
    // streaming state needs no separate register.
    assign rd_active = full[rd_bank];
    assign rd_src    = shift_rows_src(rd_idx);

    state_bank_2x16 u_bank (
        .clock   (clock),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank),
        .wr_idx  (wr_idx),
        .wr_dat  (bus.in_byte),
        .rd_bank (rd_bank),
        .rd_idx  (rd_src),
        .rd_dat  (rd_dat)
    );

    // Write and read never address the same full[] bit in one cycle: writes only
    // target a non-full bank, reads only a full one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full         <= 2'b00;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_idx       <= 4'd0;
            rd_idx       <= 4'd0;
            out_byte_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            mc_enable_q  <= 8'h00;
            col_last_q   <= 1'b0;
            state_last_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_idx <= wr_idx + 4'd1;
                if (wr_idx == 4'd15) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end

            if (rd_active) begin
                out_byte_q   <= rd_dat;
                out_valid_q  <= 1'b1;
                mc_enable_q  <= (rd_idx[1:0] == 2'd0) ? MC_EN_FIRST : MC_EN_ACC;
                col_last_q   <= (rd_idx[1:0] == 2'd3);
                state_last_q <= (rd_idx == 4'd15);
                rd_idx       <= rd_idx + 4'd1;
                // If the other bank is already full, the next cycle continues
                // streaming from it with no bubble.
                if (rd_idx == 4'd15) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end else begin
                out_byte_q   <= 8'h00;
                out_valid_q  <= 1'b0;
                mc_enable_q  <= 8'h00;
                col_last_q   <= 1'b0;
                state_last_q <= 1'b0;
            end
        end
    end

    assign bus.out_byte   = out_byte_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.mc_enable  = mc_enable_q;
    assign bus.col_last   = col_last_q;
    assign bus.state_last = state_last_q;

endmodule
